// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: system-clock PS/2 keyboard receiver.
// Sync + deglitch of PS/2 clock/data, 11-bit frame deframing with parity/stop
// checks, set-2 prefix decoding (E0/F0), event FIFO and direction-key bitmap.
// Optional macro PS2_RX_TIMEOUT_EN adds a mid-frame watchdog.
module ps2_key_event_rx #(
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned FILTER_CYCLES   = 8,
   parameter int unsigned DIR_REQUIRE_EXT = 0,
   parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [9:0] o_event,
   output logic [3:0] o_dir_held,
   output logic       o_frame_err,
   output logic       o_overflow
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("FIFO_DEPTH must be a power of 2 and >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be >= 2");
   end
   if (FILTER_CYCLES < 1) begin : g_chk_filt
      $error("FILTER_CYCLES must be >= 1");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_chk_to
      $error("TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   w_clk_s;
   logic                   w_dat_s;
   logic                   r_filt_clk;
   logic [FCW-1:0]         r_filt_cnt;
   logic                   r_strobe;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [7:0]             r_shift;
   logic [2:0]             r_bit_cnt;
   logic                   r_parity;
   logic                   w_shift_en;
   logic                   w_par_en;
   logic                   w_start;
   logic                   w_byte_ok;
   logic                   w_bad;
   logic                   w_timeout;

   logic                   r_byte_vld;
   logic [7:0]             r_byte;
   logic                   r_frame_err;
   logic                   r_ext;
   logic                   r_brk;
   logic                   w_discard;
   logic                   w_emit;
   logic [9:0]             w_event;
   logic [3:0]             r_dir;

   logic [9:0]             r_mem [FIFO_DEPTH];
   logic [AW:0]            r_wr_ptr;
   logic [AW:0]            r_rd_ptr;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_push_ok;
   logic                   r_overflow;

   assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

   // Synchronise both raw PS/2 lines; idle level is high
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      end
   end

   // Deglitch the clock and strobe once when the filtered clock falls
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_filt_clk <= 1'b1;
         r_filt_cnt <= '0;
         r_strobe   <= 1'b0;
      end else begin
         r_strobe <= 1'b0;
         if (w_clk_s == r_filt_clk) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FCW'(FILTER_CYCLES - 1)) begin
            r_filt_clk <= w_clk_s;
            r_filt_cnt <= '0;
            r_strobe   <= ~w_clk_s;
         end else begin
            r_filt_cnt <= r_filt_cnt + FCW'(1);
         end
      end
   end

`ifdef PS2_RX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;

   // Watchdog: cycles since the last strobe while a frame is in progress
   always_ff @(posedge i_clk) begin
      if (i_rst || r_state == S_IDLE || r_strobe) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   assign w_timeout = (r_state != S_IDLE) && !r_strobe &&
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Frame FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame FSM next state, advanced only on sample strobes
   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end else if (r_strobe) begin
         case (r_state)
            S_IDLE:   if (!w_dat_s) w_state_nxt = S_DATA;
            S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame FSM outputs: datapath enables and end-of-frame verdict
   always_comb begin
      w_start    = r_strobe && (r_state == S_IDLE);
      w_shift_en = r_strobe && (r_state == S_DATA);
      w_par_en   = r_strobe && (r_state == S_PARITY);
      w_byte_ok  = 1'b0;
      w_bad      = w_timeout;
      if (r_strobe && r_state == S_STOP) begin
         if ((^{r_shift, r_parity}) && w_dat_s) begin
            w_byte_ok = 1'b1;
         end else begin
            w_bad = 1'b1;
         end
      end
   end

   // Shift data bits LSB first and capture the parity bit
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_parity  <= 1'b0;
      end else begin
         if (w_start) begin
            r_bit_cnt <= '0;
         end
         if (w_shift_en) begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_par_en) begin
            r_parity <= w_dat_s;
         end
      end
   end

   // Hand the received byte to the decoder and register the error pulse
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_byte_vld  <= 1'b0;
         r_byte      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_byte_vld  <= w_byte_ok;
         r_frame_err <= w_bad;
         if (w_byte_ok) begin
            r_byte <= r_shift;
         end
      end
   end

   // Classify the decoded byte: prefix, discardable reply, or key event
   always_comb begin
      w_discard = 1'b0;
      case (r_byte)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: w_discard = 1'b1;
         default: w_discard = 1'b0;
      endcase
      w_emit  = r_byte_vld && (r_byte != 8'hE0) && (r_byte != 8'hF0) && !w_discard;
      w_event = {r_ext, r_brk, r_byte};
   end

   // Prefix flags: set by E0/F0, cleared by any other byte or a bad frame
   always_ff @(posedge i_clk) begin
      if (i_rst || w_bad) begin
         r_ext <= 1'b0;
         r_brk <= 1'b0;
      end else if (r_byte_vld) begin
         if (r_byte == 8'hE0) begin
            r_ext <= 1'b1;
         end else if (r_byte == 8'hF0) begin
            r_brk <= 1'b1;
         end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end
      end
   end

   // Direction bitmap tracks make/break independent of FIFO space
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dir <= '0;
      end else if (w_emit && (DIR_REQUIRE_EXT == 0 || r_ext)) begin
         case (r_byte)
            8'h75:   r_dir[3] <= ~r_brk;
            8'h72:   r_dir[2] <= ~r_brk;
            8'h74:   r_dir[1] <= ~r_brk;
            8'h6B:   r_dir[0] <= ~r_brk;
            default: ;
         endcase
      end
   end

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = !w_empty && i_ready;
   assign w_push_ok = w_emit && (!w_full || w_pop);

   // Event storage
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_event;
      end
   end

   // FIFO pointers and sticky overflow on a dropped event
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
         if (w_emit && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_valid     = !w_empty;
   assign o_event     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_dir_held  = r_dir;
   assign o_frame_err = r_frame_err;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb_ps2_key_event_rx: directed bench for ps2_key_event_rx.
// Define PS2_RX_TIMEOUT_EN for both files to exercise the watchdog.
module tb_ps2_key_event_rx;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned TO_CYC = 300;

   logic       i_clk      = 1'b0;
   logic       i_rst      = 1'b1;
   logic       i_ps2_clk  = 1'b1;
   logic       i_ps2_data = 1'b1;
   logic       i_ready    = 1'b0;
   logic       o_valid;
   logic [9:0] o_event;
   logic [3:0] o_dir_held;
   logic       o_frame_err;
   logic       o_overflow;

   int checks    = 0;
   int errors    = 0;
   int err_cnt   = 0;
   int valid_cyc = 0;
   logic [9:0] ev_q [$];

   ps2_key_event_rx #(
      .FIFO_DEPTH      (DEPTH),
      .SYNC_STAGES     (2),
      .FILTER_CYCLES   (8),
      .DIR_REQUIRE_EXT (0),
      .TIMEOUT_CYCLES  (TO_CYC)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_ps2_clk   (i_ps2_clk),
      .i_ps2_data  (i_ps2_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_event     (o_event),
      .o_dir_held  (o_dir_held),
      .o_frame_err (o_frame_err),
      .o_overflow  (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // Monitor on the falling edge: record popped events, error pulses, valid cycles
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_valid) valid_cyc++;
         if (o_valid && i_ready) ev_q.push_back(o_event);
         if (o_frame_err) err_cnt++;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      i_ps2_data = b;
      wait_clk(10);
      i_ps2_clk = 1'b0;
      wait_clk(20);
      i_ps2_clk = 1'b1;
      wait_clk(10);
   endtask

   task automatic send_raw(input logic [7:0] d, input logic par, input logic stp);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stp);
      i_ps2_data = 1'b1;
      wait_clk(20);
   endtask

   task automatic send_byte(input logic [7:0] d);
      send_raw(d, ~^d, 1'b1);
   endtask

   function automatic logic [9:0] ev_at(input int idx);
      if (idx < ev_q.size()) return ev_q[idx];
      return 10'bx;
   endfunction

   task automatic test_reset();
      i_rst = 1'b1;
      wait_clk(4);
      checks++;
      if (o_valid !== 1'b0 || o_event !== 10'h000) begin
         errors++;
         $display("FAIL reset_fifo: valid=%b event=%h required valid=0 event=000", o_valid, o_event);
      end
      checks++;
      if (o_dir_held !== 4'b0000) begin
         errors++;
         $display("FAIL reset_dir: got %b required 0000", o_dir_held);
      end
      checks++;
      if (o_frame_err !== 1'b0 || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: err=%b ovf=%b required 0 0", o_frame_err, o_overflow);
      end
      i_rst = 1'b0;
      wait_clk(5);
   endtask

   task automatic test_single();
      int b, v0, e0;
      b = ev_q.size(); v0 = valid_cyc; e0 = err_cnt;
      i_ready = 1'b1;
      send_byte(8'h1C);
      wait_clk(10);
      checks++;
      if (ev_q.size() - b !== 1 || ev_at(b) !== 10'h01C) begin
         errors++;
         $display("FAIL single_event: count=%0d event=%h required 1 01C", ev_q.size() - b, ev_at(b));
      end
      checks++;
      if (valid_cyc - v0 !== 1) begin
         errors++;
         $display("FAIL single_valid_len: got %0d cycles required 1", valid_cyc - v0);
      end
      checks++;
      if (err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL single_no_err: got %0d pulses required 0", err_cnt - e0);
      end
   endtask

   task automatic test_ext_break();
      int b;
      b = ev_q.size();
      send_byte(8'hE0);
      send_byte(8'h75);
      checks++;
      if (ev_q.size() - b !== 1 || ev_at(b) !== 10'h275) begin
         errors++;
         $display("FAIL ext_make: count=%0d event=%h required 1 275", ev_q.size() - b, ev_at(b));
      end
      checks++;
      if (o_dir_held !== 4'b1000) begin
         errors++;
         $display("FAIL dir_up_set: got %b required 1000", o_dir_held);
      end
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      checks++;
      if (ev_q.size() - b !== 2 || ev_at(b + 1) !== 10'h375) begin
         errors++;
         $display("FAIL ext_break: count=%0d event=%h required 2 375", ev_q.size() - b, ev_at(b + 1));
      end
      checks++;
      if (o_dir_held !== 4'b0000) begin
         errors++;
         $display("FAIL dir_up_clr: got %b required 0000", o_dir_held);
      end
   endtask

   task automatic test_frame_err();
      int b, e0;
      b = ev_q.size(); e0 = err_cnt;
      send_byte(8'hE0);
      send_raw(8'h1C, 1'b1, 1'b1);
      checks++;
      if (err_cnt - e0 !== 1 || ev_q.size() - b !== 0) begin
         errors++;
         $display("FAIL parity_err: pulses=%0d events=%0d required 1 0", err_cnt - e0, ev_q.size() - b);
      end
      send_byte(8'h1C);
      checks++;
      if (ev_q.size() - b !== 1 || ev_at(b) !== 10'h01C) begin
         errors++;
         $display("FAIL after_err_event: count=%0d event=%h required 1 01C", ev_q.size() - b, ev_at(b));
      end
      send_raw(8'h1C, 1'b0, 1'b0);
      checks++;
      if (err_cnt - e0 !== 2 || ev_q.size() - b !== 1) begin
         errors++;
         $display("FAIL stop_err: pulses=%0d events=%0d required 2 1", err_cnt - e0, ev_q.size() - b);
      end
   endtask

   task automatic test_back_to_back();
      int b;
      b = ev_q.size();
      i_ready = 1'b0;
      send_byte(8'h1C);
      send_byte(8'h15);
      send_byte(8'h24);
      checks++;
      if (o_valid !== 1'b1 || o_event !== 10'h01C) begin
         errors++;
         $display("FAIL hold_head: valid=%b event=%h required 1 01C", o_valid, o_event);
      end
      wait_clk(7);
      checks++;
      if (o_event !== 10'h01C) begin
         errors++;
         $display("FAIL hold_stable: got %h required 01C", o_event);
      end
      i_ready = 1'b1;
      wait_clk(10);
      checks++;
      if (ev_q.size() - b !== 3 || ev_at(b) !== 10'h01C || ev_at(b + 1) !== 10'h015 ||
          ev_at(b + 2) !== 10'h024) begin
         errors++;
         $display("FAIL order: count=%0d events=%h %h %h required 3 01C 015 024",
                  ev_q.size() - b, ev_at(b), ev_at(b + 1), ev_at(b + 2));
      end
   endtask

   task automatic test_overflow();
      int b, v0, bad;
      i_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_byte(8'h15);
      checks++;
      if (o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_no_ovf: got %b required 0", o_overflow);
      end
      send_byte(8'h15);
      checks++;
      if (o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got %b required 1", o_overflow);
      end
      b = ev_q.size(); v0 = valid_cyc;
      i_ready = 1'b1;
      wait_clk(20);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (ev_at(b + i) !== 10'h015) bad++;
      checks++;
      if (ev_q.size() - b !== DEPTH || bad !== 0) begin
         errors++;
         $display("FAIL ovf_drain: count=%0d wrong=%0d required %0d 0", ev_q.size() - b, bad, DEPTH);
      end
      checks++;
      if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: valid=%b ovf=%b required 0 1", o_valid, o_overflow);
      end
   endtask

   task automatic test_glitch();
      int b, e0;
      b = ev_q.size(); e0 = err_cnt;
      i_ps2_data = 1'b0;
      i_ps2_clk  = 1'b0;
      wait_clk(3);
      i_ps2_clk  = 1'b1;
      wait_clk(5);
      i_ps2_data = 1'b1;
      wait_clk(30);
      checks++;
      if (ev_q.size() - b !== 0 || err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL glitch_ignored: events=%0d pulses=%0d required 0 0", ev_q.size() - b, err_cnt - e0);
      end
      send_byte(8'h1C);
      checks++;
      if (ev_q.size() - b !== 1 || ev_at(b) !== 10'h01C || err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL glitch_then_frame: count=%0d event=%h pulses=%0d required 1 01C 0",
                  ev_q.size() - b, ev_at(b), err_cnt - e0);
      end
   endtask

`ifdef PS2_RX_TIMEOUT_EN
   task automatic test_timeout();
      int b, e0;
      b = ev_q.size(); e0 = err_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      i_ps2_data = 1'b1;
      wait_clk(TO_CYC - 60);
      checks++;
      if (err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL timeout_early: got %0d pulses required 0", err_cnt - e0);
      end
      wait_clk(100);
      checks++;
      if (err_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL timeout_pulse: got %0d pulses required 1", err_cnt - e0);
      end
      send_byte(8'h1C);
      checks++;
      if (ev_q.size() - b !== 1 || ev_at(b) !== 10'h01C) begin
         errors++;
         $display("FAIL timeout_recover: count=%0d event=%h required 1 01C", ev_q.size() - b, ev_at(b));
      end
   endtask
`endif

   task automatic test_reset_midframe();
      int b, e0;
      i_ready = 1'b1;
      send_byte(8'h75);
      checks++;
      if (o_dir_held !== 4'b1000) begin
         errors++;
         $display("FAIL alias_up_set: got %b required 1000", o_dir_held);
      end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      i_rst = 1'b1;
      wait_clk(2);
      checks++;
      if (o_valid !== 1'b0 || o_event !== 10'h000 || o_dir_held !== 4'b0000 ||
          o_frame_err !== 1'b0 || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: valid=%b event=%h dir=%b err=%b ovf=%b required all 0",
                  o_valid, o_event, o_dir_held, o_frame_err, o_overflow);
      end
      i_rst = 1'b0;
      i_ps2_data = 1'b1;
      wait_clk(20);
      b = ev_q.size(); e0 = err_cnt;
      send_byte(8'h1C);
      checks++;
      if (ev_q.size() - b !== 1 || ev_at(b) !== 10'h01C || err_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL midreset_recover: count=%0d event=%h pulses=%0d required 1 01C 0",
                  ev_q.size() - b, ev_at(b), err_cnt - e0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_ext_break();
      test_frame_err();
      test_back_to_back();
      test_overflow();
      test_glitch();
`ifdef PS2_RX_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
